// File: rtl/iu_fetch_sequencer_pkg.sv
// Shared definitions for the instruction-unit fetch sequencer.
//   iu_state_t : sequencer state encoding (also exported on state_out)
//   PCSEL_*    : PC source select codes driven on pc_sel during a redirect
package iu_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_REDIRECT = 3'd4,
        ST_HALT     = 3'd5
    } iu_state_t;

    localparam logic [1:0] PCSEL_REL  = 2'b00;
    localparam logic [1:0] PCSEL_JMP  = 2'b01;
    localparam logic [1:0] PCSEL_REG  = 2'b10;
    localparam logic [1:0] PCSEL_JMP8 = 2'b11;

endpackage

// File: rtl/iu_wait_timer.sv
// Instruction-memory read wait timer.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous clear (dominates enable)
//   enable     : advance the count by one
//   done       : count has reached IM_WAIT
module iu_wait_timer #(
    parameter int unsigned IM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [3:0] WAIT_LIM = 4'(IM_WAIT);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign done = (cnt == WAIT_LIM);

endmodule

// File: rtl/iu_fetch_sequencer.sv
// Instruction-unit fetch sequencer: steps PC / instruction memory / IR through
// FETCH -> LOAD -> ISSUE and applies PC redirects requested by execute.
//   clk, reset           : clock, asynchronous active-low reset
//   go, halt             : start/resume, stop after current instruction/redirect
//   ir_ack               : consumer has taken the instruction in IR
//   br_req, br_sel       : redirect request and PC source (held until br_ack)
//   pc_sel/pc_ld/pc_inc  : PC controls
//   im_cs/im_rd/im_wr    : instruction memory controls (im_wr tied low)
//   ir_ld, ir_valid      : IR load strobe, IR holds an unconsumed instruction
//   br_ack               : one-cycle redirect-applied pulse
//   busy, fetch_cnt      : activity flag, instructions loaded since reset
//   state_out            : current state encoding
module iu_fetch_sequencer
    import iu_fetch_sequencer_pkg::*;
#(
    parameter int unsigned IM_WAIT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             halt,
    input  logic             ir_ack,
    input  logic             br_req,
    input  logic [1:0]       br_sel,
    output logic [1:0]       pc_sel,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             im_cs,
    output logic             im_rd,
    output logic             im_wr,
    output logic             ir_ld,
    output logic             ir_valid,
    output logic             br_ack,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [2:0]       state_out
);

    iu_state_t  state, state_nxt;
    logic [1:0] br_sel_q;
    logic       tmr_done;
    logic       issue_ack;

    // Counter runs only while in FETCH and restarts on the cycle it expires,
    // so every FETCH visit lasts exactly IM_WAIT+1 cycles.
    iu_wait_timer #(
        .IM_WAIT (IM_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_done || (state != ST_FETCH)),
        .enable (state == ST_FETCH),
        .done   (tmr_done)
    );

    assign issue_ack = (state == ST_ISSUE) && ir_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            br_sel_q  <= PCSEL_REL;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (issue_ack && br_req) begin
                br_sel_q <= br_sel;
            end
            if (state == ST_LOAD) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (go && !halt) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (tmr_done) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Redirect wins over halt; halt is re-examined at REDIRECT.
                if (ir_ack) begin
                    if (br_req)    state_nxt = ST_REDIRECT;
                    else if (halt) state_nxt = ST_HALT;
                    else           state_nxt = ST_FETCH;
                end
            end
            ST_REDIRECT: begin
                state_nxt = halt ? ST_HALT : ST_FETCH;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore decode of the state register: no input reaches an output
    // combinationally, and reset forces every strobe low immediately.
    always_comb begin
        pc_sel   = PCSEL_REL;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        im_cs    = 1'b0;
        im_rd    = 1'b0;
        ir_ld    = 1'b0;
        ir_valid = 1'b0;
        br_ack   = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_FETCH: begin
                im_cs = 1'b1;
                im_rd = 1'b1;
                busy  = 1'b1;
            end
            ST_LOAD: begin
                im_cs  = 1'b1;
                im_rd  = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
                busy   = 1'b1;
            end
            ST_ISSUE: begin
                ir_valid = 1'b1;
                busy     = 1'b1;
            end
            ST_REDIRECT: begin
                pc_ld  = 1'b1;
                pc_sel = br_sel_q;
                br_ack = 1'b1;
                busy   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign im_wr     = 1'b0;
    assign state_out = state;

endmodule

// File: tb/tb_iu_fetch_sequencer.sv
module tb_iu_fetch_sequencer;

    // Strobe word layout: {pc_sel[1:0], pc_ld, pc_inc, im_cs, im_rd, im_wr,
    //                      ir_ld, ir_valid, br_ack, busy}
    localparam logic [31:0] S_IDLE  = 32'h000;
    localparam logic [31:0] S_FETCH = 32'h061;
    localparam logic [31:0] S_LOAD  = 32'h0E9;
    localparam logic [31:0] S_ISSUE = 32'h005;
    localparam logic [31:0] S_RD_01 = 32'h303;
    localparam logic [31:0] S_RD_10 = 32'h503;
    localparam logic [31:0] S_RD_11 = 32'h703;

    logic       clk;
    logic       reset;
    logic       go, halt, ir_ack, br_req;
    logic [1:0] br_sel;
    logic [1:0] pc_sel;
    logic       pc_ld, pc_inc, im_cs, im_rd, im_wr, ir_ld, ir_valid, br_ack, busy;
    logic [3:0] fetch_cnt;
    logic [2:0] state_out;

    logic       go0, halt0, ir_ack0, br_req0;
    logic [1:0] br_sel0;
    logic [1:0] pc_sel0;
    logic       pc_ld0, pc_inc0, im_cs0, im_rd0, im_wr0, ir_ld0, ir_valid0, br_ack0, busy0;
    logic [7:0] fetch_cnt0;
    logic [2:0] state_out0;

    logic [10:0] obs, obs0;

    int unsigned n_vec;
    int unsigned n_err;

    iu_fetch_sequencer #(
        .IM_WAIT (1),
        .CNT_W   (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .halt      (halt),
        .ir_ack    (ir_ack),
        .br_req    (br_req),
        .br_sel    (br_sel),
        .pc_sel    (pc_sel),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .im_cs     (im_cs),
        .im_rd     (im_rd),
        .im_wr     (im_wr),
        .ir_ld     (ir_ld),
        .ir_valid  (ir_valid),
        .br_ack    (br_ack),
        .busy      (busy),
        .fetch_cnt (fetch_cnt),
        .state_out (state_out)
    );

    iu_fetch_sequencer #(
        .IM_WAIT (0),
        .CNT_W   (8)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .go        (go0),
        .halt      (halt0),
        .ir_ack    (ir_ack0),
        .br_req    (br_req0),
        .br_sel    (br_sel0),
        .pc_sel    (pc_sel0),
        .pc_ld     (pc_ld0),
        .pc_inc    (pc_inc0),
        .im_cs     (im_cs0),
        .im_rd     (im_rd0),
        .im_wr     (im_wr0),
        .ir_ld     (ir_ld0),
        .ir_valid  (ir_valid0),
        .br_ack    (br_ack0),
        .busy      (busy0),
        .fetch_cnt (fetch_cnt0),
        .state_out (state_out0)
    );

    assign obs  = {pc_sel, pc_ld, pc_inc, im_cs, im_rd, im_wr,
                   ir_ld, ir_valid, br_ack, busy};
    assign obs0 = {pc_sel0, pc_ld0, pc_inc0, im_cs0, im_rd0, im_wr0,
                   ir_ld0, ir_valid0, br_ack0, busy0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        go      = 1'b0; halt  = 1'b0; ir_ack  = 1'b0; br_req  = 1'b0; br_sel  = 2'b00;
        go0     = 1'b0; halt0 = 1'b0; ir_ack0 = 1'b0; br_req0 = 1'b0; br_sel0 = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'(obs), S_IDLE);
        chk("rst_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_no_go", 32'(obs), S_IDLE);

        // 1: first fetch, IM_WAIT=1
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t1_fetch_a", 32'(obs), S_FETCH);
        chk("t1_state_fetch", 32'(state_out), 32'd1);
        tick();
        chk("t1_fetch_b", 32'(obs), S_FETCH);
        tick();
        chk("t1_load", 32'(obs), S_LOAD);
        chk("t1_cnt_pre", 32'(fetch_cnt), 32'd0);
        tick();
        chk("t1_issue", 32'(obs), S_ISSUE);
        chk("t1_cnt", 32'(fetch_cnt), 32'd1);

        // 2: br_req held without ack, then ack -> redirect with latched br_sel
        br_req = 1'b1;
        br_sel = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_issue", 32'(obs), S_ISSUE);
        end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        br_req = 1'b0;
        br_sel = 2'b11;
        chk("t2_redirect", 32'(obs), S_RD_10);
        chk("t2_state_rd", 32'(state_out), 32'd4);
        tick();
        chk("t2_ack_pulse", 32'(obs), S_FETCH);
        tick();
        tick();
        chk("t2_load", 32'(obs), S_LOAD);
        tick();
        chk("t2_issue", 32'(obs), S_ISSUE);
        chk("t2_cnt", 32'(fetch_cnt), 32'd2);

        // 3: br_req + halt on ack -> REDIRECT then HALT; go resumes
        ir_ack = 1'b1;
        br_req = 1'b1;
        halt   = 1'b1;
        br_sel = 2'b01;
        tick();
        ir_ack = 1'b0;
        br_req = 1'b0;
        chk("t3_redirect", 32'(obs), S_RD_01);
        tick();
        chk("t3_halt", 32'(obs), S_IDLE);
        chk("t3_state_halt", 32'(state_out), 32'd5);
        go = 1'b1;
        tick();
        chk("t3_go_and_halt", 32'(state_out), 32'd5);
        halt = 1'b0;
        tick();
        go = 1'b0;
        chk("t3_resume", 32'(obs), S_FETCH);

        // 4a: asynchronous reset mid-FETCH
        #2 reset = 1'b0;
        #1;
        chk("t4_fetch_rst", 32'(obs), S_IDLE);
        chk("t4_fetch_rst_cnt", 32'(fetch_cnt), 32'd0);
        chk("t4_fetch_rst_state", 32'(state_out), 32'd0);
        #1 reset = 1'b1;
        tick();
        chk("t4_idle_after", 32'(obs), S_IDLE);

        // 4b: asynchronous reset mid-REDIRECT
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_issue", 32'(obs), S_ISSUE);
        chk("t4_cnt", 32'(fetch_cnt), 32'd1);
        ir_ack = 1'b1;
        br_req = 1'b1;
        br_sel = 2'b11;
        tick();
        ir_ack = 1'b0;
        br_req = 1'b0;
        chk("t4_redirect", 32'(obs), S_RD_11);
        #2 reset = 1'b0;
        #1;
        chk("t4_rd_rst", 32'(obs), S_IDLE);
        chk("t4_rd_rst_cnt", 32'(fetch_cnt), 32'd0);
        #1 reset = 1'b1;
        tick();
        chk("t4_idle_after_rd", 32'(obs), S_IDLE);

        // 5: 16 back-to-back acked fetches, 4-bit counter wraps
        ir_ack = 1'b1;
        go     = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tick();
            tick();
            chk("t5_issue", 32'(obs), S_ISSUE);
            chk("t5_cnt", 32'(fetch_cnt), 32'(k % 16));
            tick();
        end
        chk("t5_refetch", 32'(obs), S_FETCH);

        // ack with halt only -> HALT
        ir_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("t5b_issue", 32'(obs), S_ISSUE);
        ir_ack = 1'b1;
        halt   = 1'b1;
        tick();
        ir_ack = 1'b0;
        chk("t5b_halt", 32'(state_out), 32'd5);
        halt = 1'b0;

        // 6: IM_WAIT=0 instance, one-cycle FETCH
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        chk("t6_fetch", 32'(obs0), S_FETCH);
        tick();
        chk("t6_load", 32'(obs0), S_LOAD);
        tick();
        chk("t6_issue", 32'(obs0), S_ISSUE);
        chk("t6_cnt", 32'(fetch_cnt0), 32'd1);

        // 6: random ack/br_req traffic, invariants every cycle
        go0 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            ir_ack0 = 1'($urandom_range(0, 1));
            br_req0 = 1'($urandom_range(0, 1));
            br_sel0 = 2'($urandom_range(0, 3));
            tick();
            chk("t6_ld_inc", 32'(pc_ld0 & pc_inc0), 32'd0);
            chk("t6_im_wr", 32'(im_wr0), 32'd0);
            if (!pc_ld0) chk("t6_pcsel_idle", 32'(pc_sel0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
